// File: rtl/alu_pkg.sv
// Shared definitions for the 4-bit registered ALU and the driver that feeds it:
// opcode encodings, driver state encoding and the ALU data width.
package alu_pkg;

    localparam int unsigned ALU_W = 4;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_NOT = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_LT  = 3'b110;
    localparam logic [2:0] OP_EQ  = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } drv_state_t;

endpackage

// File: rtl/alu_op_driver.sv
// Initiator for the registered ALU: takes one op over a valid/ready request,
// holds operands while the ALU settles, and returns the captured result.
module alu_op_driver
    import alu_pkg::*;
#(
    parameter int unsigned LAT   = 1,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [ALU_W-1:0] req_a,
    input  logic [ALU_W-1:0] req_b,
    output logic [2:0]       alu_sel,
    output logic [ALU_W-1:0] alu_a,
    output logic [ALU_W-1:0] alu_b,
    input  logic [ALU_W-1:0] alu_y,
    input  logic             alu_zf,
    input  logic             alu_of,
    input  logic             alu_cf,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [ALU_W-1:0] rsp_y,
    output logic             rsp_zf,
    output logic             rsp_of,
    output logic             rsp_cf,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    localparam int unsigned LAT_W = (LAT < 2) ? 1 : $clog2(LAT + 1);

    drv_state_t       state;
    drv_state_t       next_state;
    logic [LAT_W-1:0] wait_cnt;
    logic             accept;
    logic             capture;
    logic             rsp_done;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    // A response handshake frees the driver in the same edge, so a waiting
    // request can be taken without an idle cycle in between.
    assign req_ready = rst_n && ((state == IDLE) || ((state == RESP) && rsp_ready));
    assign busy      = (state != IDLE);

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        capture    = 1'b0;
        rsp_done   = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    accept     = 1'b1;
                    next_state = WAIT;
                end
            end
            WAIT: begin
                if (wait_cnt == '0) begin
                    capture    = 1'b1;
                    next_state = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_done = 1'b1;
                    if (req_valid) begin
                        accept     = 1'b1;
                        next_state = WAIT;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_sel  <= '0;
            alu_a    <= '0;
            alu_b    <= '0;
            wait_cnt <= '0;
        end else if (accept) begin
            alu_sel  <= req_op;
            alu_a    <= req_a;
            alu_b    <= req_b;
            wait_cnt <= LAT_W'(LAT);
        end else if ((state == WAIT) && (wait_cnt != '0)) begin
            wait_cnt <= wait_cnt - LAT_W'(1);
        end
    end

    // Capture and handshake never coincide: capture only happens in WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_y     <= '0;
            rsp_zf    <= 1'b0;
            rsp_of    <= 1'b0;
            rsp_cf    <= 1'b0;
            op_count  <= '0;
        end else if (capture) begin
            rsp_valid <= 1'b1;
            rsp_y     <= alu_y;
            rsp_zf    <= alu_zf;
            rsp_of    <= alu_of;
            rsp_cf    <= alu_cf;
        end else if (rsp_done) begin
            rsp_valid <= 1'b0;
            op_count  <= sat_inc(op_count);
        end
    end

endmodule

// File: tb/tb_alu_op_driver.sv
// Bench for alu_op_driver: a registered 4-bit ALU sits behind the driver and
// responses are compared against an integer-arithmetic reference model.
module tb_alu_op_driver;
    import alu_pkg::*;

    typedef struct packed {
        logic [3:0] y;
        logic       zf;
        logic       of;
        logic       cf;
    } res_t;

    logic       clk;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [2:0] req_op;
    logic [3:0] req_a;
    logic [3:0] req_b;
    logic [2:0] alu_sel;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [3:0] alu_y;
    logic       alu_zf;
    logic       alu_of;
    logic       alu_cf;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_y;
    logic       rsp_zf;
    logic       rsp_of;
    logic       rsp_cf;
    logic       busy;
    logic [15:0] op_count;

    logic       req_ready2;
    logic [2:0] alu_sel2;
    logic [3:0] alu_a2;
    logic [3:0] alu_b2;
    logic       rsp_valid2;
    logic [3:0] rsp_y2;
    logic       rsp_zf2;
    logic       rsp_of2;
    logic       rsp_cf2;
    logic       busy2;
    logic [1:0] op_count2;

    int total;
    int bad;
    int exp_count;

    alu_op_driver #(.LAT(1), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b),
        .alu_y(alu_y), .alu_zf(alu_zf), .alu_of(alu_of), .alu_cf(alu_cf),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_y(rsp_y), .rsp_zf(rsp_zf), .rsp_of(rsp_of), .rsp_cf(rsp_cf),
        .busy(busy), .op_count(op_count)
    );

    // Narrow-counter instance; it sees identical stimulus, so it shares the ALU.
    alu_op_driver #(.LAT(1), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready2),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .alu_sel(alu_sel2), .alu_a(alu_a2), .alu_b(alu_b2),
        .alu_y(alu_y), .alu_zf(alu_zf), .alu_of(alu_of), .alu_cf(alu_cf),
        .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready),
        .rsp_y(rsp_y2), .rsp_zf(rsp_zf2), .rsp_of(rsp_of2), .rsp_cf(rsp_cf2),
        .busy(busy2), .op_count(op_count2)
    );

    // Registered ALU peer (one cycle of latency).
    res_t       alu_nxt;
    res_t       alu_q;
    logic [4:0] t5;

    always_comb begin
        alu_nxt = '0;
        t5      = '0;
        case (alu_sel)
            OP_ADD: begin
                t5         = {1'b0, alu_a} + {1'b0, alu_b};
                alu_nxt.y  = t5[3:0];
                alu_nxt.cf = t5[4];
                alu_nxt.of = (alu_a[3] == alu_b[3]) && (t5[3] != alu_a[3]);
                alu_nxt.zf = (t5[3:0] == 4'd0);
            end
            OP_SUB: begin
                t5         = {1'b0, alu_a} - {1'b0, alu_b};
                alu_nxt.y  = t5[3:0];
                alu_nxt.cf = t5[4];
                alu_nxt.of = (alu_a[3] != alu_b[3]) && (t5[3] != alu_a[3]);
                alu_nxt.zf = (t5[3:0] == 4'd0);
            end
            OP_NOT: alu_nxt.y = ~alu_a;
            OP_AND: alu_nxt.y = alu_a & alu_b;
            OP_OR:  alu_nxt.y = alu_a | alu_b;
            OP_XOR: alu_nxt.y = alu_a ^ alu_b;
            OP_LT:  alu_nxt.y = {3'b000, $signed(alu_a) < $signed(alu_b)};
            OP_EQ:  alu_nxt.y = {3'b000, alu_a == alu_b};
            default: alu_nxt = '0;
        endcase
    end

    always_ff @(posedge clk) alu_q <= alu_nxt;

    assign alu_y  = alu_q.y;
    assign alu_zf = alu_q.zf;
    assign alu_of = alu_q.of;
    assign alu_cf = alu_q.cf;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic res_t ref_alu(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        int   ua, ub, sa, sb, r, sr;
        res_t res;
        ua  = int'(a);
        ub  = int'(b);
        sa  = (ua >= 8) ? ua - 16 : ua;
        sb  = (ub >= 8) ? ub - 16 : ub;
        res = '0;
        case (op)
            OP_ADD: begin
                r      = ua + ub;
                sr     = sa + sb;
                res.y  = 4'(r % 16);
                res.cf = (r > 15);
                res.of = (sr > 7) || (sr < -8);
                res.zf = (r % 16 == 0);
            end
            OP_SUB: begin
                r      = ua - ub;
                sr     = sa - sb;
                res.y  = 4'((r + 16) % 16);
                res.cf = (ua < ub);
                res.of = (sr > 7) || (sr < -8);
                res.zf = (r == 0);
            end
            OP_NOT:  res.y = 4'(15 - ua);
            OP_AND:  res.y = a & b;
            OP_OR:   res.y = a | b;
            OP_XOR:  res.y = a ^ b;
            OP_LT:   res.y = (sa < sb) ? 4'd1 : 4'd0;
            default: res.y = (ua == ub) ? 4'd1 : 4'd0;
        endcase
        return res;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        int n;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin
            step();
            n++;
        end
        step();
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            step();
            lat++;
        end
        if (!rsp_valid) begin
            total++;
            bad++;
            $display("FAIL rsp_timeout: rsp_valid=%0b after %0d cycles, want 1", rsp_valid, lat);
        end
    endtask

    task automatic test_reset();
        #12;
        total++;
        if ({req_ready, rsp_valid, busy} !== 3'b000) begin
            bad++;
            $display("FAIL reset_ctrl: got %b want 000", {req_ready, rsp_valid, busy});
        end
        total++;
        if (op_count !== 16'd0) begin
            bad++;
            $display("FAIL reset_count: got %0d want 0", op_count);
        end
        total++;
        if ({alu_sel, alu_a, alu_b} !== 11'd0) begin
            bad++;
            $display("FAIL reset_alu: got %h want 0", {alu_sel, alu_a, alu_b});
        end
        total++;
        if ({rsp_y, rsp_zf, rsp_of, rsp_cf} !== 7'd0) begin
            bad++;
            $display("FAIL reset_rsp: got %h want 0", {rsp_y, rsp_zf, rsp_of, rsp_cf});
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        total++;
        if (req_ready !== 1'b1) begin
            bad++;
            $display("FAIL idle_ready: got %b want 1", req_ready);
        end
    endtask

    task automatic test_add();
        int   lat;
        res_t e;
        rsp_ready = 1'b1;
        issue(OP_ADD, 4'h7, 4'h1);
        total++;
        if ({busy, alu_sel, alu_a, alu_b} !== {1'b1, OP_ADD, 4'h7, 4'h1}) begin
            bad++;
            $display("FAIL add_drive: got %h want %h", {busy, alu_sel, alu_a, alu_b}, {1'b1, OP_ADD, 4'h7, 4'h1});
        end
        wait_rsp(lat);
        e = ref_alu(OP_ADD, 4'h7, 4'h1);
        total++;
        if (lat !== 2) begin
            bad++;
            $display("FAIL add_latency: got %0d want 2", lat);
        end
        total++;
        if ({rsp_y, rsp_zf, rsp_of, rsp_cf} !== e) begin
            bad++;
            $display("FAIL add_result: got %h want %h", {rsp_y, rsp_zf, rsp_of, rsp_cf}, e);
        end
        step();
        exp_count++;
        total++;
        if ({rsp_valid, busy, op_count} !== {2'b00, 16'(exp_count)}) begin
            bad++;
            $display("FAIL add_done: got valid=%b busy=%b cnt=%0d want 0 0 %0d", rsp_valid, busy, op_count, exp_count);
        end
    endtask

    task automatic test_wrap_sub();
        int         lat;
        res_t       e;
        logic [2:0] ops[2];
        logic [3:0] as[2];
        logic [3:0] bs[2];
        ops[0] = OP_ADD; as[0] = 4'hF; bs[0] = 4'h1;
        ops[1] = OP_SUB; as[1] = 4'h3; bs[1] = 4'h5;
        rsp_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            issue(ops[i], as[i], bs[i]);
            wait_rsp(lat);
            e = ref_alu(ops[i], as[i], bs[i]);
            total++;
            if ({rsp_y, rsp_zf, rsp_of, rsp_cf} !== e) begin
                bad++;
                $display("FAIL wrap_sub_%0d: got %h want %h", i, {rsp_y, rsp_zf, rsp_of, rsp_cf}, e);
            end
            step();
            exp_count++;
        end
    endtask

    task automatic test_compares();
        int         lat;
        res_t       e;
        logic [2:0] ops[5];
        logic [3:0] as[5];
        logic [3:0] bs[5];
        ops[0] = OP_LT;  as[0] = 4'h8; bs[0] = 4'h1;
        ops[1] = OP_EQ;  as[1] = 4'h9; bs[1] = 4'h9;
        ops[2] = OP_EQ;  as[2] = 4'h9; bs[2] = 4'h8;
        ops[3] = OP_NOT; as[3] = 4'h5; bs[3] = 4'h0;
        ops[4] = OP_LT;  as[4] = 4'h1; bs[4] = 4'hF;
        rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            issue(ops[i], as[i], bs[i]);
            wait_rsp(lat);
            e = ref_alu(ops[i], as[i], bs[i]);
            total++;
            if ({rsp_y, rsp_zf, rsp_of, rsp_cf} !== e) begin
                bad++;
                $display("FAIL compare_%0d: got %h want %h", i, {rsp_y, rsp_zf, rsp_of, rsp_cf}, e);
            end
            step();
            exp_count++;
        end
    endtask

    task automatic test_back_to_back();
        int   lat;
        res_t e;
        rsp_ready = 1'b0;
        issue(OP_OR, 4'h5, 4'h3);
        wait_rsp(lat);
        e = ref_alu(OP_OR, 4'h5, 4'h3);
        for (int i = 0; i < 3; i++) begin
            total++;
            if ({rsp_valid, req_ready, rsp_y, rsp_zf, rsp_of, rsp_cf} !== {2'b10, e}) begin
                bad++;
                $display("FAIL hold_%0d: got %h want %h", i, {rsp_valid, req_ready, rsp_y, rsp_zf, rsp_of, rsp_cf}, {2'b10, e});
            end
            step();
        end
        req_op    = OP_XOR;
        req_a     = 4'hC;
        req_b     = 4'hA;
        req_valid = 1'b1;
        rsp_ready = 1'b1;
        #1;
        total++;
        if (req_ready !== 1'b1) begin
            bad++;
            $display("FAIL b2b_ready: got %b want 1", req_ready);
        end
        step();
        req_valid = 1'b0;
        exp_count++;
        total++;
        if ({rsp_valid, busy, alu_sel, op_count} !== {2'b01, OP_XOR, 16'(exp_count)}) begin
            bad++;
            $display("FAIL b2b_accept: got v=%b busy=%b sel=%0d cnt=%0d want 0 1 %0d %0d", rsp_valid, busy, alu_sel, op_count, OP_XOR, exp_count);
        end
        wait_rsp(lat);
        e = ref_alu(OP_XOR, 4'hC, 4'hA);
        total++;
        if ({lat[3:0], rsp_y, rsp_zf, rsp_of, rsp_cf} !== {4'd2, e}) begin
            bad++;
            $display("FAIL b2b_result: got lat=%0d res=%h want 2 %h", lat, {rsp_y, rsp_zf, rsp_of, rsp_cf}, e);
        end
        step();
        exp_count++;
    endtask

    task automatic test_reset_mid_wait();
        bit seen;
        rsp_ready = 1'b1;
        issue(OP_ADD, 4'h1, 4'h1);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        exp_count = 0;
        total++;
        if ({req_ready, rsp_valid, busy, op_count} !== 19'd0) begin
            bad++;
            $display("FAIL midreset_ctrl: got rdy=%b v=%b busy=%b cnt=%0d want all 0", req_ready, rsp_valid, busy, op_count);
        end
        total++;
        if ({alu_sel, alu_a, alu_b, rsp_y} !== 15'd0) begin
            bad++;
            $display("FAIL midreset_data: got %h want 0", {alu_sel, alu_a, alu_b, rsp_y});
        end
        step();
        step();
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (rsp_valid) seen = 1'b1;
        end
        total++;
        if ({seen, busy, op_count} !== 18'd0) begin
            bad++;
            $display("FAIL midreset_after: got seen=%b busy=%b cnt=%0d want 0 0 0", seen, busy, op_count);
        end
    endtask

    task automatic test_saturation();
        int         lat;
        int         sat;
        res_t       e;
        logic [2:0] op;
        logic [3:0] a;
        logic [3:0] b;
        rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            op = 3'($urandom_range(0, 7));
            a  = 4'($urandom_range(0, 15));
            b  = 4'($urandom_range(0, 15));
            issue(op, a, b);
            wait_rsp(lat);
            e = ref_alu(op, a, b);
            total++;
            if ({req_ready2, rsp_valid2, busy2, alu_sel2, alu_a2, alu_b2, rsp_y2, rsp_zf2, rsp_of2, rsp_cf2}
                !== {3'b111, op, a, b, e}) begin
                bad++;
                $display("FAIL sat_rsp_%0d: got %h want %h", k,
                         {req_ready2, rsp_valid2, busy2, alu_sel2, alu_a2, alu_b2, rsp_y2, rsp_zf2, rsp_of2, rsp_cf2},
                         {3'b111, op, a, b, e});
            end
            step();
            exp_count++;
            sat = (exp_count > 3) ? 3 : exp_count;
            total++;
            if ({op_count2, op_count} !== {2'(sat), 16'(exp_count)}) begin
                bad++;
                $display("FAIL sat_count_%0d: got %0d/%0d want %0d/%0d", k, op_count2, op_count, sat, exp_count);
            end
        end
    endtask

    task automatic test_random();
        int         lat;
        int         hold;
        res_t       e;
        logic [2:0] op;
        logic [3:0] a;
        logic [3:0] b;
        for (int k = 0; k < 40; k++) begin
            op = 3'($urandom_range(0, 7));
            a  = 4'($urandom_range(0, 15));
            b  = 4'($urandom_range(0, 15));
            rsp_ready = 1'b0;
            issue(op, a, b);
            wait_rsp(lat);
            e = ref_alu(op, a, b);
            total++;
            if ({lat[3:0], rsp_y, rsp_zf, rsp_of, rsp_cf} !== {4'd2, e}) begin
                bad++;
                $display("FAIL rand_%0d op=%0d a=%h b=%h: got lat=%0d res=%h want 2 %h", k, op, a, b, lat, {rsp_y, rsp_zf, rsp_of, rsp_cf}, e);
            end
            hold = $urandom_range(0, 2);
            for (int h = 0; h < hold; h++) begin
                step();
                total++;
                if ({rsp_valid, rsp_y, rsp_zf, rsp_of, rsp_cf} !== {1'b1, e}) begin
                    bad++;
                    $display("FAIL rand_hold_%0d: got %h want %h", k, {rsp_valid, rsp_y, rsp_zf, rsp_of, rsp_cf}, {1'b1, e});
                end
            end
            rsp_ready = 1'b1;
            step();
            rsp_ready = 1'b0;
            exp_count++;
            total++;
            if ({rsp_valid, op_count} !== {1'b0, 16'(exp_count)}) begin
                bad++;
                $display("FAIL rand_count_%0d: got v=%b cnt=%0d want 0 %0d", k, rsp_valid, op_count, exp_count);
            end
        end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        exp_count = 0;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_op    = 3'd0;
        req_a     = 4'd0;
        req_b     = 4'd0;
        rsp_ready = 1'b1;
        test_reset();
        test_add();
        test_wrap_sub();
        test_compares();
        test_back_to_back();
        test_reset_mid_wait();
        test_saturation();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_op_driver.md
Name: alu_op_driver

Overview:
- Initiator side of the 4-bit registered ALU interface.
- Accepts operation requests over a valid/ready handshake and drives select_mode/A/B into the ALU, holding them stable.
- Waits out the ALU's registered latency, captures Y/ZF/OF/CF and returns them over a valid/ready response channel.
- Sits between the control logic (or testbench sequencer) and the ALU instance.

Parameters:
- LAT, 1: clk edges between operands being stable at the ALU and its result being readable; minimum 1.
- CNT_W, 16: width of the completed-operation counter.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst_n  in  1  reset; asynchronous, active-low. One clock; reset is asynchronous and active-low.
- req_valid  in  1  request present.
- req_ready  out  1  driver can accept a request.
- req_op  in  3  ALU opcode (select_mode encoding).
- req_a  in  4  operand A.
- req_b  in  4  operand B.
- alu_sel  out  3  to ALU select_mode.
- alu_a  out  4  to ALU A.
- alu_b  out  4  to ALU B.
- alu_y  in  4  from ALU Y.
- alu_zf, alu_of, alu_cf  in  1 each  from ALU flags.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_y  out  4  captured result.
- rsp_zf, rsp_of, rsp_cf  out  1 each  captured flags.
- busy  out  1  high in WAIT or RESP.
- op_count  out  CNT_W  completed responses, saturating.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; alu_sel/alu_a/alu_b=0; rsp_y=0; all rsp flags=0; rsp_valid=0; op_count=0; busy=0. req_ready is forced 0 while rst_n is low.
- Reset mid-operation: the in-flight op is discarded, no response is produced, and the stale ALU output is ignored.
- States: IDLE, WAIT, RESP.
- req_ready = rst_n && (IDLE || (RESP && rsp_ready)). This is combinational from state and rsp_ready and allows back-to-back ops.
- Accept edge (req_valid && req_ready):
  - register req_op/req_a/req_b into alu_sel/alu_a/alu_b;
  - load wait counter with LAT;
  - go to WAIT.
- WAIT:
  - alu_* are held constant.
  - Each edge with counter != 0: decrement.
  - Edge with counter == 0: capture alu_y and the flags into rsp_*, set rsp_valid, go to RESP.
  - Accept-to-rsp_valid latency = LAT+1 cycles (2 for LAT=1).
- RESP:
  - rsp_* are held stable while rsp_valid && !rsp_ready.
  - Edge with rsp_ready && !req_valid: clear rsp_valid, go to IDLE, increment op_count.
  - Edge with rsp_ready && req_valid: clear rsp_valid, increment op_count, and accept the new request in the same edge (state goes to WAIT).
- rsp_valid drops on the response handshake edge and rises only on a capture edge; it never glitches.
- op_count saturates at all-ones and does not wrap.
- In IDLE, alu_* keep the last issued values; they are not cleared.
- Flags pass through unmodified; for opcodes 010..111 the ALU supplies zeros.
- For opcodes 110/111 only rsp_y[0] is meaningful and rsp_y[3:1] = 0 as delivered by the ALU.
- No illegal opcodes exist; all 8 encodings are forwarded.
- req_valid while busy and not in a RESP handshake: the request is not accepted and must be held by the requester.
- busy = (state != IDLE).

Decomposition:
- Shared package alu_pkg holds:
  - opcode constants OP_ADD=000, OP_SUB=001, OP_NOT=010, OP_AND=011, OP_OR=100, OP_XOR=101, OP_LT=110, OP_EQ=111;
  - driver state enum (IDLE, WAIT, RESP);
  - ALU data width constant 4.
- No sub-module: the latency counter and FSM stay inline.
- The bench instantiates the existing ALU behind this driver.

Test Plan:
- ADD: op=000, a=7, b=1, rsp_ready=1 -> rsp_valid exactly 2 cycles after accept; y=8, OF=1, CF=0, ZF=0; op_count=1.
- ADD wrap, then SUB borrow:
  - ADD a=F, b=1 -> y=0, ZF=1, CF=1, OF=0.
  - Then SUB a=3, b=5 -> y=E, CF=1, OF=0, ZF=0.
- Compares: LT a=8, b=1 -> y=1 (signed, -8<1); EQ a=9, b=9 -> y=1; EQ a=9, b=8 -> y=0; all flags 0.
- Backpressure and back-to-back:
  - rsp_ready=0 for 3 cycles -> rsp_* stable, req_ready=0.
  - Then rsp_ready=1 with req_valid=1 (XOR a=C, b=A) -> same-edge accept; next rsp y=6; no idle cycle.
- Reset mid-WAIT: drop rst_n one cycle after accept -> all outputs 0 immediately; after release no rsp_valid and op_count=0.
- Saturation: CNT_W=2, 5 completed ops -> op_count reads 3 after the 3rd op and stays 3.
